// File: rtl/int_fp_acc.sv
// Group accumulator for int_fp_mul products: saturating signed INT16 or FP16
// (flush-to-zero, round-to-nearest-even) sums, one result per in_last-terminated group.
module int_fp_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_err,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_err,
  output logic        out_ovf
);

  // state | meaning
  // IDLE  | accepting beats (INT beats accumulate here directly)
  // ALIGN | FP exponent compare and significand alignment
  // NORM  | FP add/sub, normalize, round, accumulator update
  // OUT   | group sum presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_NORM, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        first_q, first_d;
  logic        mode_q, mode_d;
  logic        last_q, last_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        spc_q, spc_d;
  logic [15:0] spcv_q, spcv_d;
  logic        sgn_q, sgn_d;
  logic        sub_q, sub_d;
  logic [4:0]  exp_q, exp_d;
  logic [13:0] mant_l_q, mant_l_d;
  logic [13:0] mant_s_q, mant_s_d;

  logic        in_fire, mode_eff;
  logic [15:0] base;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = acc_q;
  assign out_err   = err_q;
  assign out_ovf   = ovf_q;
  assign in_fire   = in_valid && in_ready;
  assign mode_eff  = first_q ? mode : mode_q;
  assign base      = first_q ? 16'h0000 : acc_q;

  logic signed [16:0] isum;
  logic               int_ovf;
  logic [15:0]        int_res;

  always_comb begin
    isum    = $signed({base[15], base}) + $signed({in_data[15], in_data});
    int_ovf = isum[16] ^ isum[15];
    int_res = isum[15:0];
    if (int_ovf) int_res = isum[16] ? 16'h8000 : 16'h7FFF;
  end

  logic        a_s, b_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [4:0]  a_e, b_e, dexp;
  logic [10:0] m_big, m_small;
  logic [40:0] shf;
  logic        spc_hit;
  logic [15:0] spc_val;

  always_comb begin
    a_s     = opa_q[15];
    b_s     = opb_q[15];
    a_e     = opa_q[14:10];
    b_e     = opb_q[14:10];
    a_zero  = (a_e == 5'd0);
    b_zero  = (b_e == 5'd0);
    a_inf   = (a_e == 5'h1F) && (opa_q[9:0] == 10'd0);
    b_inf   = (b_e == 5'h1F) && (opb_q[9:0] == 10'd0);
    a_nan   = (a_e == 5'h1F) && (opa_q[9:0] != 10'd0);
    b_nan   = (b_e == 5'h1F) && (opb_q[9:0] != 10'd0);
    a_big   = (opa_q[14:0] >= opb_q[14:0]);
    m_big   = a_big ? {1'b1, opa_q[9:0]} : {1'b1, opb_q[9:0]};
    m_small = a_big ? {1'b1, opb_q[9:0]} : {1'b1, opa_q[9:0]};
    dexp    = a_big ? (a_e - b_e) : (b_e - a_e);
    // 30 spare bits cover the largest normal-to-normal exponent gap
    shf     = {m_small, 30'b0} >> dexp;

    spc_hit = 1'b1;
    spc_val = 16'h0000;
    if (a_nan || b_nan)       spc_val = 16'h7E00;
    else if (a_inf && b_inf)  spc_val = (a_s != b_s) ? 16'h7E00 : opa_q;
    else if (a_inf)           spc_val = opa_q;
    else if (b_inf)           spc_val = opb_q;
    else if (a_zero && b_zero) spc_val = (a_s && b_s) ? 16'h8000 : 16'h0000;
    else if (a_zero)          spc_val = opb_q;
    else if (b_zero)          spc_val = opa_q;
    else                      spc_hit = 1'b0;
  end

  logic [14:0]       sum;
  logic [3:0]        lz;
  logic [13:0]       nrm;
  logic signed [6:0] e_pre, e_rnd;
  logic              rnd_up;
  logic [11:0]       m_rnd;
  logic [15:0]       fp_res;
  logic              fp_ovf;

  always_comb begin
    sum = sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
    lz = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (sum[i]) lz = 4'(13 - i);
    end
    if (sum[14]) begin
      nrm   = {sum[14:2], sum[1] | sum[0]};
      e_pre = $signed({2'b00, exp_q}) + 7'sd1;
    end else begin
      nrm   = sum[13:0] << lz;
      e_pre = $signed({2'b00, exp_q}) - $signed({3'b000, lz});
    end
    rnd_up = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
    m_rnd  = {1'b0, nrm[13:3]} + {11'b0, rnd_up};
    e_rnd  = m_rnd[11] ? (e_pre + 7'sd1) : e_pre;
    fp_ovf = 1'b0;
    if (sum == 15'd0)          fp_res = 16'h0000;
    else if (e_pre <= 7'sd0)   fp_res = {sgn_q, 15'h0000};
    else if (e_rnd >= 7'sd31) begin
      fp_res = {sgn_q, 15'h7C00};
      fp_ovf = 1'b1;
    end else begin
      fp_res = {sgn_q, e_rnd[4:0], m_rnd[11] ? m_rnd[10:1] : m_rnd[9:0]};
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    first_d  = first_q;
    mode_d   = mode_q;
    last_d   = last_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    spc_d    = spc_q;
    spcv_d   = spcv_q;
    sgn_d    = sgn_q;
    sub_d    = sub_q;
    exp_d    = exp_q;
    mant_l_d = mant_l_q;
    mant_s_d = mant_s_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          first_d = 1'b0;
          mode_d  = mode_eff;
          last_d  = in_last;
          err_d   = (first_q ? 1'b0 : err_q) | in_err;
          ovf_d   = first_q ? 1'b0 : ovf_q;
          if (!mode_eff) begin
            acc_d   = int_res;
            ovf_d   = (first_q ? 1'b0 : ovf_q) | int_ovf;
            state_d = in_last ? S_OUT : S_IDLE;
          end else begin
            opa_d   = base;
            opb_d   = in_data;
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        spc_d    = spc_hit;
        spcv_d   = spc_val;
        sgn_d    = a_big ? a_s : b_s;
        sub_d    = a_s ^ b_s;
        exp_d    = a_big ? a_e : b_e;
        mant_l_d = {m_big, 3'b000};
        mant_s_d = {shf[40:28], shf[27] | (|shf[26:0])};
        state_d  = S_NORM;
      end
      S_NORM: begin
        acc_d   = spc_q ? spcv_q : fp_res;
        ovf_d   = ovf_q | (~spc_q & fp_ovf);
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          first_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'h0000;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      first_q  <= 1'b1;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      opa_q    <= 16'h0000;
      opb_q    <= 16'h0000;
      spc_q    <= 1'b0;
      spcv_q   <= 16'h0000;
      sgn_q    <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= 5'd0;
      mant_l_q <= 14'd0;
      mant_s_q <= 14'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      first_q  <= first_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      spc_q    <= spc_d;
      spcv_q   <= spcv_d;
      sgn_q    <= sgn_d;
      sub_q    <= sub_d;
      exp_q    <= exp_d;
      mant_l_q <= mant_l_d;
      mant_s_q <= mant_s_d;
    end
  end

endmodule
